// File: rtl/fifo_write_sched.sv
`default_nettype none
// ============================================================================
// fifo_write_sched : round-robin scheduler sharing one FIFO write port among
//                    NREQ toggle-triggered requesters (optional clear-before-write).
// Optional feature macro: FIFO_WR_OVF_CNT_EN (saturating overflow counter).
// Revision: 1.0
// ============================================================================
module fifo_write_sched #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       trigWrite,
  input  logic [NREQ-1:0]       clrFifo,
  input  logic [NREQ*WIDTH-1:0] dataIn,
  input  logic                  fifoFull,
  output logic                  sclr,
  output logic                  writeReq,
  output logic [WIDTH-1:0]      fifoData,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [7:0]            ovfCount
);

  localparam int SELW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [NREQ-1:0]  prevTrig_q;
  logic [NREQ-1:0]  pending_q;
  logic [NREQ-1:0]  holdClr_q;
  logic [WIDTH-1:0] holdData_q [NREQ];
  logic [SELW-1:0]  sel_q;
  logic [SELW-1:0]  lastGrant_q;
  logic             sclr_q;
  logic             writeReq_q;
  logic [WIDTH-1:0] fifoData_q;
  logic [NREQ-1:0]  grant_q;

  logic [NREQ-1:0]  toggle_d;
  logic [NREQ-1:0]  retire_d;
  logic [NREQ-1:0]  accept_d;
  logic [NREQ-1:0]  pending_d;
  logic [SELW-1:0]  nextSel_d;
  logic             anyPend_d;

  // A request retiring on this edge frees its slot for a toggle on the same edge.
  assign toggle_d  = trigWrite ^ prevTrig_q;
  assign retire_d  = (state_q == WRITE && !fifoFull) ? (NREQ'(1) << sel_q) : '0;
  assign accept_d  = toggle_d & (~pending_q | retire_d);
  assign pending_d = (pending_q & ~retire_d) | accept_d;

  // Descending scan so the nearest candidate after lastGrant wins.
  always_comb begin
    logic [SELW-1:0] cand;
    nextSel_d = '0;
    anyPend_d = 1'b0;
    cand      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = SELW'((int'(lastGrant_q) + k) % NREQ);
      if (pending_q[cand]) begin
        nextSel_d = cand;
        anyPend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prevTrig_q <= '0;
      pending_q  <= '0;
      holdClr_q  <= '0;
      for (int i = 0; i < NREQ; i++) begin
        holdData_q[i] <= '0;
      end
    end else begin
      prevTrig_q <= trigWrite;
      pending_q  <= pending_d;
      for (int i = 0; i < NREQ; i++) begin
        if (accept_d[i]) begin
          holdData_q[i] <= dataIn[i*WIDTH +: WIDTH];
          holdClr_q[i]  <= clrFifo[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      lastGrant_q <= SELW'(NREQ - 1);
      sclr_q      <= 1'b0;
      writeReq_q  <= 1'b0;
      fifoData_q  <= '0;
      grant_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclr_q     <= 1'b0;
          writeReq_q <= 1'b0;
          grant_q    <= '0;
          if (anyPend_d) begin
            sel_q       <= nextSel_d;
            lastGrant_q <= nextSel_d;
            fifoData_q  <= holdData_q[nextSel_d];
            state_q     <= holdClr_q[nextSel_d] ? CLEAR : WRITE;
          end
        end
        CLEAR: begin
          sclr_q  <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          sclr_q <= 1'b0;
          if (!fifoFull) begin
            writeReq_q <= 1'b1;
            grant_q    <= NREQ'(1) << sel_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          writeReq_q <= 1'b0;
          grant_q    <= '0;
          state_q    <= IDLE;
        end
        default: begin
          sclr_q     <= 1'b0;
          writeReq_q <= 1'b0;
          grant_q    <= '0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign sclr     = sclr_q;
  assign writeReq = writeReq_q;
  assign fifoData = fifoData_q;
  assign grant    = grant_q;
  assign busy     = (state_q != IDLE) || (|pending_q);

`ifdef FIFO_WR_OVF_CNT_EN
  logic [NREQ-1:0] ovf_d;
  logic [8:0]      ovfSum_d;
  logic [7:0]      ovfCount_q;

  assign ovf_d = toggle_d & pending_q & ~retire_d;

  // Each simultaneous overflow adds one; the 9th bit flags saturation.
  always_comb begin
    ovfSum_d = {1'b0, ovfCount_q};
    for (int i = 0; i < NREQ; i++) begin
      ovfSum_d = ovfSum_d + {8'd0, ovf_d[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovfCount_q <= 8'd0;
    end else begin
      ovfCount_q <= ovfSum_d[8] ? 8'hFF : ovfSum_d[7:0];
    end
  end

  assign ovfCount = ovfCount_q;
`else
  assign ovfCount = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_sched.sv
`default_nettype none
// tb_fifo_write_sched : scoreboard bench; a transaction-level model predicts each
// write (edge, word, grant) and each sclr pulse, a monitor pops and compares.
module tb_fifo_write_sched;
  localparam int NREQ  = 2;
  localparam int WIDTH = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       trigWrite = '0;
  logic [NREQ-1:0]       clrFifo = '0;
  logic [NREQ*WIDTH-1:0] dataIn = '0;
  logic                  fifoFull = 1'b0;
  logic                  sclr;
  logic                  writeReq;
  logic [WIDTH-1:0]      fifoData;
  logic [NREQ-1:0]       grant;
  logic                  busy;
  logic [7:0]            ovfCount;

  fifo_write_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .trigWrite(trigWrite), .clrFifo(clrFifo),
    .dataIn(dataIn), .fifoFull(fifoFull), .sclr(sclr), .writeReq(writeReq),
    .fifoData(fifoData), .grant(grant), .busy(busy), .ovfCount(ovfCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  typedef struct {
    int               e;
    logic [WIDTH-1:0] w;
    logic [NREQ-1:0]  g;
  } exp_t;

  exp_t wq[$];
  int   sq[$];
  logic [NREQ-1:0] glog[$];
  int nwrites = 0;
  int last_wr_cyc = 0;
  bit mon_en = 0;

  // Reference model: requests are slots (one per requester); a selected
  // transaction may write from sel+1 (+1 with clear) on the first non-full
  // edge; after a write the next selection is possible two edges later.
  logic [NREQ-1:0]  m_prev, m_pend, m_hclr;
  logic [WIDTH-1:0] m_hdata [NREQ];
  int               m_last, m_sel, m_ready, m_nextsel, m_ovf;
  bit               m_act, m_busy;
  logic [WIDTH-1:0] m_word;

  task automatic model_reset();
    m_prev = '0; m_pend = '0; m_hclr = '0;
    for (int i = 0; i < NREQ; i++) m_hdata[i] = '0;
    m_last = NREQ - 1; m_sel = 0; m_ready = 0; m_nextsel = 0; m_ovf = 0;
    m_act = 0; m_busy = 0; m_word = '0;
    wq.delete(); sq.delete();
  endtask

  task automatic model_edge();
    int edge_n;
    bit wrote;
    logic [NREQ-1:0] g;
    edge_n = cyc + 1;
    wrote = 0;
    if (m_act && edge_n >= m_ready && !fifoFull) begin
      g = '0; g[m_sel] = 1'b1;
      wq.push_back('{edge_n, m_word, g});
      m_pend[m_sel] = 1'b0; m_act = 0; m_nextsel = edge_n + 2; wrote = 1;
    end else if (!m_act && edge_n >= m_nextsel) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (!m_act && m_pend[idx]) begin
          m_act = 1; m_sel = idx; m_last = idx; m_word = m_hdata[idx];
          m_ready = edge_n + 1 + int'(m_hclr[idx]);
          if (m_hclr[idx]) sq.push_back(edge_n + 1);
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (trigWrite[i] != m_prev[i]) begin
        m_prev[i] = trigWrite[i];
        if (!m_pend[i]) begin
          m_pend[i] = 1'b1; m_hdata[i] = dataIn[i*WIDTH +: WIDTH]; m_hclr[i] = clrFifo[i];
        end else if (m_ovf < 255) begin
          m_ovf++;
        end
      end
    end
    m_busy = m_act || wrote || (|m_pend);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic req(input int i, input bit c, input logic [WIDTH-1:0] d);
    trigWrite[i] = ~trigWrite[i];
    clrFifo[i] = c;
    dataIn[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic monitor_cycle();
    bit exp_s;
    exp_t it;
    int exp_ovf;
    exp_s = 0;
    if (sq.size() > 0 && sq[0] == cyc) begin
      exp_s = 1;
      void'(sq.pop_front());
    end
    chk("sclr", sclr, exp_s);
    if (writeReq) begin
      if (wq.size() == 0) begin
        chk("unexpected_write", writeReq, 0);
      end else begin
        it = wq.pop_front();
        chk("write_edge", cyc, it.e);
        chk("fifoData", fifoData, it.w);
        chk("grant", grant, it.g);
      end
      glog.push_back(grant);
      nwrites++;
      last_wr_cyc = cyc;
    end else begin
      chk("grant_idle", grant, 0);
    end
    chk("busy", busy, m_busy);
`ifdef FIFO_WR_OVF_CNT_EN
    exp_ovf = m_ovf;
`else
    exp_ovf = 0;
`endif
    chk("ovfCount", ovfCount, exp_ovf);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) monitor_cycle();
    end
  end

  initial begin
    int base, k0, g0, budget, who, ovf_exp;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_sclr", sclr, 0);
    chk("rst_writeReq", writeReq, 0);
    chk("rst_fifoData", fifoData, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovfCount", ovfCount, 0);
    mon_en = 1;

    // single write, requester 0
    base = nwrites; k0 = cyc + 1;
    req(0, 1'b0, 32'hA5A5_0001);
    repeat (8) tick();
    chk("single_writes", nwrites - base, 1);
    chk("single_latency", last_wr_cyc - k0, 2);

    // clear then write, requester 1
    base = nwrites; k0 = cyc + 1;
    req(1, 1'b1, 32'h0000_BEEF);
    repeat (8) tick();
    chk("clear_writes", nwrites - base, 1);
    chk("clear_latency", last_wr_cyc - k0, 3);
    chk("clear_data", fifoData, 32'h0000_BEEF);

    // fairness: both toggle, granted one re-toggles
    g0 = glog.size();
    req(0, 1'b0, $urandom);
    req(1, 1'b0, $urandom);
    for (int n = 0; n < 6; n++) begin
      base = nwrites; budget = 0;
      while (nwrites == base && budget < 20) begin
        tick();
        budget++;
      end
      if (nwrites == base) begin
        failures++;
        $display("FAIL fair_timeout: no write within %0d cycles", budget);
        break;
      end
      who = glog[glog.size()-1][1] ? 1 : 0;
      if (n < 5) req(who, 1'b0, $urandom);
    end
    repeat (6) tick();
    for (int n = 0; n < 6; n++) begin
      if (g0 + n < glog.size()) chk("fair_seq", glog[g0+n], (n % 2 == 0) ? 2'b01 : 2'b10);
      else chk("fair_seq_missing", glog.size(), g0 + 6);
    end

    // full stall: 5 cycles of fifoFull while in WRITE
    base = nwrites; k0 = cyc + 1;
    fifoFull = 1'b1;
    req(0, 1'b0, 32'h1234_5678);
    repeat (7) tick();
    fifoFull = 1'b0;
    repeat (5) tick();
    chk("stall_writes", nwrites - base, 1);
    chk("stall_latency", last_wr_cyc - k0, 7);

    // overflow: three toggles while the first is still pending
    base = nwrites;
    fifoFull = 1'b1;
    req(0, 1'b0, 32'hCAFE_0001); tick();
    req(0, 1'b0, 32'hCAFE_0002); tick();
    req(0, 1'b0, 32'hCAFE_0003); tick();
    repeat (3) tick();
    fifoFull = 1'b0;
    repeat (6) tick();
    chk("ovf_writes", nwrites - base, 1);
    chk("ovf_word", fifoData, 32'hCAFE_0001);
`ifdef FIFO_WR_OVF_CNT_EN
    ovf_exp = 2;
`else
    ovf_exp = 0;
`endif
    chk("ovf_count", ovfCount, ovf_exp);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      fifoFull = ($urandom % 5) == 0;
      for (int i = 0; i < NREQ; i++) begin
        clrFifo[i] = ($urandom % 3) == 0;
        dataIn[i*WIDTH +: WIDTH] = $urandom;
        if (($urandom % 4) == 0) trigWrite[i] = ~trigWrite[i];
      end
      tick();
    end
    fifoFull = 1'b0;
    repeat (20) tick();

    // reset while sclr is high
    req(1, 1'b1, 32'hDEAD_0001);
    repeat (3) tick();
    chk("pre_rst_sclr", sclr, 1);
    base = nwrites;
    rst = 1'b1;
    trigWrite = '0;
    #1;
    chk("async_rst_sclr", sclr, 0);
    chk("async_rst_writeReq", writeReq, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_writes", nwrites - base, 0);

    // recovery write
    base = nwrites;
    req(0, 1'b0, 32'h0BAD_F00D);
    repeat (8) tick();
    chk("recover_writes", nwrites - base, 1);
    chk("recover_grant", glog[glog.size()-1], 2'b01);

    chk("pending_writes_left", wq.size(), 0);
    chk("pending_sclr_left", sq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
